self_made_wrapper: RTL and testbench
====================================

# self_made_wrapper

Pixel-stream processing stage between the RGB image source and the output capture. Each cycle it accepts one RGB pixel with its raster coordinates, converts it to luminance, and optionally applies a horizontal [1 2 1]/4 smoothing filter. It drives the result on all three output channels after a fixed latency. Pixels outside the active display area are forced to zero.

## Interface
Parameters:
- P_IMGDEPTH, 8: bits per colour channel.
- HEIGHT, 300: total lines per frame, including blanking.
- WIDTH, 400: total pixels per line, including blanking.
- V_DISP, 240: active lines.
- H_DISP, 320: active pixels per line.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- h_count_in  in  $clog2(WIDTH+1)  horizontal position of the current input pixel.
- v_count_in  in  $clog2(HEIGHT+1)  vertical position of the current input pixel.
- r_in, g_in, b_in  in  P_IMGDEPTH each  input pixel channels.
- r_out, g_out, b_out  out  P_IMGDEPTH each  processed pixel; all three carry the same value.

## Operation
- Active pixel: h_count_in < H_DISP and v_count_in < V_DISP. Every other pixel is blanking.
- Luma: Y = (77·R + 150·G + 29·B + 128) >> 8.
  - Intermediate width is at least 2·P_IMGDEPTH+1 bits.
  - The coefficients sum to 256, so Y ≤ 255 and no saturation is needed.
- Smoothing: out = (Yl + 2·Yc + Yr + 2) >> 2, using a P_IMGDEPTH+2-bit sum.
  - Yl and Yr are the horizontal neighbours on the same line.
- Edge replication:
  - At h=0, Yl = Yc.
  - At h=H_DISP-1, Yr = Yc.
  - Blanking samples never enter the filter.
- Each output carries the active flag of its pixel. An inactive output pixel drives 0 on all channels.
- No vertical filtering; there is no line memory.
- Input counts are trusted and are not range-checked.

## Timing
- Fixed latency of 3 cycles. The output for the input sampled at rising edge t is valid after rising edge t+3.
- One pixel per cycle. There is no handshake and no stall.
- Latency is identical with and without SELFMADE_SMOOTH_EN.
- Reset:
  - While rst is sampled high, all pipeline registers, active flags and outputs clear to 0 on the next edge.
  - Reset mid-frame discards in-flight pixels.
  - After rst falls, outputs stay 0 for 3 cycles, then track the input with latency 3.
- Line boundary: the right neighbour of h=H_DISP-1 is replicated. It is never the following blanking sample or the next line's h=0.
- Frame wrap (v: HEIGHT-1 → 0) needs no special handling. The filter is line-local.

## Configuration
- SELFMADE_SMOOTH_EN:
  - Defined: the [1 2 1]/4 horizontal smoothing is applied to Y.
  - Undefined: out = Y directly. The window registers are replaced by plain delay registers so latency stays 3.

## Structure
- Package selfmade_pkg holds:
  - luma coefficients (77, 150, 29) and rounding constant 128;
  - LATENCY = 3;
  - a pixel struct {active, y}.
- Sub-module rgb2gray: combinational or single-register RGB→Y conversion. It is instantiated once.
- The window, edge replication and output mux live in self_made_wrapper.

## Test plan
- Reset and latency: hold rst high 5 cycles with R=G=B=100 active, then release. Outputs are 0 during reset and for 3 cycles after release, then 100.
- Colour conversion: constant active R=255, G=0, B=0. Output is 77 after steady state; G=255 alone gives 149; B=255 alone gives 29.
- Blanking: inputs 255 with h=H_DISP or v=V_DISP. Output is 0 three cycles later.
- Step edge with SMOOTH_EN: Y=0 for h<160, Y=200 for h≥160. Output is 50 at h=159, 150 at h=160, and 200 at h=161.
- Line edges: uniform Y=80 line whose h=0 and h=H_DISP-1 neighbours are blanking. Output is 80 at both edges, with no blanking contamination.
- Without SMOOTH_EN: same step stimulus gives 0 at h=159 and 200 at h=160, still with latency 3.

Source files
------------

// File: rtl/selfmade_pkg.sv
// Shared constants and pixel type for the self_made_wrapper luma/smoothing stage.
package selfmade_pkg;

  localparam int unsigned LUMA_R     = 77;
  localparam int unsigned LUMA_G     = 150;
  localparam int unsigned LUMA_B     = 29;
  localparam int unsigned LUMA_RND   = 128;
  localparam int unsigned LUMA_SHIFT = 8;
  localparam int unsigned LATENCY    = 3;
  localparam int unsigned PIX_YW     = 16;

  // y is sized for the widest supported channel; narrower depths zero-extend.
  typedef struct packed {
    logic              active;
    logic [PIX_YW-1:0] y;
  } pixel_t;

endpackage

// File: rtl/rgb2gray.sv
// Registered RGB to luma converter: Y = (77R + 150G + 29B + 128) >> 8.
module rgb2gray
  import selfmade_pkg::*;
#(
  parameter int P_IMGDEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  active_i,
  input  logic [P_IMGDEPTH-1:0] r_i,
  input  logic [P_IMGDEPTH-1:0] g_i,
  input  logic [P_IMGDEPTH-1:0] b_i,
  output logic [P_IMGDEPTH-1:0] y_o,
  output logic                  active_o
);

  localparam int unsigned SW = 2 * P_IMGDEPTH + 1;

  logic [SW-1:0]         sum_d;
  logic [P_IMGDEPTH-1:0] y_d, y_q;
  logic                  active_q;

  // Coefficients sum to 256, so the shifted result never exceeds full scale.
  always_comb begin
    sum_d = SW'(LUMA_R) * SW'(r_i) + SW'(LUMA_G) * SW'(g_i)
          + SW'(LUMA_B) * SW'(b_i) + SW'(LUMA_RND);
    y_d   = P_IMGDEPTH'(sum_d >> LUMA_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= '0;
      active_q <= 1'b0;
    end else begin
      y_q      <= y_d;
      active_q <= active_i;
    end
  end

  assign y_o      = y_q;
  assign active_o = active_q;

endmodule

// File: rtl/self_made_wrapper.sv
// Pixel stage: RGB->luma, optional [1 2 1]/4 horizontal smoothing (SELFMADE_SMOOTH_EN),
// blanking forced to zero, fixed 3-cycle latency in both builds.
module self_made_wrapper
  import selfmade_pkg::*;
#(
  parameter int P_IMGDEPTH = 8,
  parameter int HEIGHT     = 300,
  parameter int WIDTH      = 400,
  parameter int V_DISP     = 240,
  parameter int H_DISP     = 320
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(WIDTH+1)-1:0]   h_count_in,
  input  logic [$clog2(HEIGHT+1)-1:0]  v_count_in,
  input  logic [P_IMGDEPTH-1:0]        r_in,
  input  logic [P_IMGDEPTH-1:0]        g_in,
  input  logic [P_IMGDEPTH-1:0]        b_in,
  output logic [P_IMGDEPTH-1:0]        r_out,
  output logic [P_IMGDEPTH-1:0]        g_out,
  output logic [P_IMGDEPTH-1:0]        b_out
);

  logic                  act_in;
  logic [P_IMGDEPTH-1:0] y1;
  logic                  act1;
  pixel_t                c_d, c_q, res_d, res_q;
  logic [P_IMGDEPTH-1:0] out_d, out_q;

  assign act_in = (int'(h_count_in) < H_DISP) && (int'(v_count_in) < V_DISP);

  rgb2gray #(
    .P_IMGDEPTH(P_IMGDEPTH)
  ) u_rgb2gray (
    .clk     (clk),
    .rst     (rst),
    .active_i(act_in),
    .r_i     (r_in),
    .g_i     (g_in),
    .b_i     (b_in),
    .y_o     (y1),
    .active_o(act1)
  );

`ifdef SELFMADE_SMOOTH_EN
  logic                  first_in, last_in;
  logic                  first1_q, last1_q, first_c_q, last_c_q;
  logic [P_IMGDEPTH-1:0] yc, yl_q, yl_sel, yr_sel;
  logic [P_IMGDEPTH+1:0] sum_d;

  assign first_in = (h_count_in == '0);
  assign last_in  = (int'(h_count_in) == H_DISP - 1);

  // Window: yl_q = left, c_q = centre, y1 = right (one pixel ahead of centre).
  always_ff @(posedge clk) begin
    if (rst) begin
      first1_q  <= 1'b0;
      last1_q   <= 1'b0;
      first_c_q <= 1'b0;
      last_c_q  <= 1'b0;
      yl_q      <= '0;
    end else begin
      first1_q  <= first_in;
      last1_q   <= last_in;
      first_c_q <= first1_q;
      last_c_q  <= last1_q;
      yl_q      <= yc;
    end
  end

  // Edge replication keeps blanking samples and adjacent lines out of the sum.
  always_comb begin
    yc     = P_IMGDEPTH'(c_q.y);
    yl_sel = first_c_q ? yc : yl_q;
    yr_sel = last_c_q  ? yc : y1;
    sum_d  = (P_IMGDEPTH+2)'(yl_sel) + ((P_IMGDEPTH+2)'(yc) << 1)
           + (P_IMGDEPTH+2)'(yr_sel) + (P_IMGDEPTH+2)'(2);
    res_d        = '0;
    res_d.active = c_q.active;
    res_d.y      = PIX_YW'(sum_d >> 2);
  end
`else
  always_comb begin
    res_d = c_q;
  end
`endif

  always_comb begin
    c_d        = '0;
    c_d.active = act1;
    c_d.y      = PIX_YW'(y1);
    out_d      = res_q.active ? P_IMGDEPTH'(res_q.y) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q   <= '0;
      res_q <= '0;
      out_q <= '0;
    end else begin
      c_q   <= c_d;
      res_q <= res_d;
      out_q <= out_d;
    end
  end

  assign r_out = out_q;
  assign g_out = out_q;
  assign b_out = out_q;

endmodule

// File: tb/tb_self_made_wrapper.sv
// Self-checking bench for self_made_wrapper; expectations follow SELFMADE_SMOOTH_EN when defined.
module tb_self_made_wrapper;

  localparam int P      = 8;
  localparam int HEIGHT = 300;
  localparam int WIDTH  = 400;
  localparam int V_DISP = 240;
  localparam int H_DISP = 320;

  logic         clk = 1'b0;
  logic         rst;
  logic [8:0]   h_count_in;
  logic [8:0]   v_count_in;
  logic [P-1:0] r_in, g_in, b_in;
  logic [P-1:0] r_out, g_out, b_out;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int hq[$];
  int lr[WIDTH], lg[WIDTH], lb[WIDTH];
  int ly[WIDTH], lexp[WIDTH], obs_line[WIDTH];

  always #5 clk = ~clk;

  self_made_wrapper #(
    .P_IMGDEPTH(P),
    .HEIGHT    (HEIGHT),
    .WIDTH     (WIDTH),
    .V_DISP    (V_DISP),
    .H_DISP    (H_DISP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .h_count_in(h_count_in),
    .v_count_in(v_count_in),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out)
  );

  function automatic int luma(input int r, input int g, input int b);
    return (77 * r + 150 * g + 29 * b + 128) / 256;
  endfunction

  // Reference output of every pixel of line vv from the whole-line picture.
  function automatic void model_line(input int vv);
    for (int h = 0; h < WIDTH; h++) ly[h] = luma(lr[h], lg[h], lb[h]);
    for (int h = 0; h < WIDTH; h++) begin
      if (h >= H_DISP || vv >= V_DISP) lexp[h] = 0;
      else begin
`ifdef SELFMADE_SMOOTH_EN
        int l, rr;
        l  = (h == 0) ? ly[h] : ly[h-1];
        rr = (h == H_DISP - 1) ? ly[h] : ly[h+1];
        lexp[h] = (l + 2 * ly[h] + rr + 2) / 4;
`else
        lexp[h] = ly[h];
`endif
      end
    end
  endfunction

  // Called at a falling edge: sample outputs, retire the oldest expectation, drive a new pixel.
  task automatic step(input int hh, input int vv, input int rv, input int gv, input int bv,
                      input int ev, output int obs, output int expv, output int hp);
    if ($isunknown({r_out, g_out, b_out})) obs = -2;
    else if (r_out != g_out || g_out != b_out) obs = -1;
    else obs = int'(r_out);
    expv = exp_q.pop_front();
    hp   = hq.pop_front();
    h_count_in = 9'(hh);
    v_count_in = 9'(vv);
    r_in = P'(rv);
    g_in = P'(gv);
    b_in = P'(bv);
    exp_q.push_back(ev);
    hq.push_back(hh);
    @(negedge clk);
  endtask

  task automatic stream_line(input int vv, input string tag);
    int obs, expv, hp;
    model_line(vv);
    for (int hh = 0; hh < WIDTH; hh++) begin
      step(hh, vv, lr[hh], lg[hh], lb[hh], lexp[hh], obs, expv, hp);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s v=%0d h=%0d: got %0d expected %0d", tag, vv, hp, obs, expv);
      end
      if (hp >= 0) obs_line[hp] = obs;
    end
  endtask

  task automatic fill_line(input int rv, input int gv, input int bv);
    for (int h = 0; h < WIDTH; h++) begin
      lr[h] = rv; lg[h] = gv; lb[h] = bv;
    end
  endtask

  task automatic restart_queue();
    exp_q = '{0, 0, 0, 0};
    hq    = '{-1, -1, -1, -1};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    h_count_in = '0; v_count_in = '0;
    r_in = 8'd100; g_in = 8'd100; b_in = 8'd100;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({r_out, g_out, b_out} !== '0) begin
        errors++;
        $display("FAIL reset_hold: got %0d/%0d/%0d expected 0", r_out, g_out, b_out);
      end
    end
    rst = 1'b0;
    restart_queue();
    fill_line(100, 100, 100);
    stream_line(0, "reset_release");
    checks++;
    if (obs_line[10] !== 100) begin
      errors++;
      $display("FAIL reset_grey100: got %0d expected 100", obs_line[10]);
    end
  endtask

  task automatic test_color();
    int want[3] = '{77, 149, 29};
    for (int c = 0; c < 3; c++) begin
      fill_line(c == 0 ? 255 : 0, c == 1 ? 255 : 0, c == 2 ? 255 : 0);
      stream_line(1 + c, "color");
      checks++;
      if (obs_line[100] !== want[c]) begin
        errors++;
        $display("FAIL color_ch%0d: got %0d expected %0d", c, obs_line[100], want[c]);
      end
    end
  endtask

  task automatic test_blanking();
    fill_line(255, 255, 255);
    stream_line(V_DISP, "blank_v");
    checks++;
    if (obs_line[50] !== 0) begin
      errors++;
      $display("FAIL blank_v_disp: got %0d expected 0", obs_line[50]);
    end
    stream_line(5, "blank_h");
    checks++;
    if (obs_line[H_DISP] !== 0 || obs_line[H_DISP-1] !== 255) begin
      errors++;
      $display("FAIL blank_h_disp: got %0d,%0d expected 255,0", obs_line[H_DISP-1], obs_line[H_DISP]);
    end
  endtask

  task automatic test_step_edge();
    int e159, e160, e161;
    for (int h = 0; h < WIDTH; h++) begin
      lr[h] = (h < 160) ? 0 : 200; lg[h] = lr[h]; lb[h] = lr[h];
    end
    stream_line(6, "step");
`ifdef SELFMADE_SMOOTH_EN
    e159 = 50;  e160 = 150; e161 = 200;
`else
    e159 = 0;   e160 = 200; e161 = 200;
`endif
    checks++;
    if (obs_line[159] !== e159 || obs_line[160] !== e160 || obs_line[161] !== e161) begin
      errors++;
      $display("FAIL step_edge: got %0d,%0d,%0d expected %0d,%0d,%0d",
               obs_line[159], obs_line[160], obs_line[161], e159, e160, e161);
    end
  endtask

  task automatic test_line_edges();
    for (int h = 0; h < WIDTH; h++) begin
      lr[h] = (h < H_DISP) ? 80 : 255; lg[h] = lr[h]; lb[h] = lr[h];
    end
    stream_line(7, "line_edge");
    checks++;
    if (obs_line[0] !== 80 || obs_line[H_DISP-1] !== 80) begin
      errors++;
      $display("FAIL line_edges: got %0d,%0d expected 80,80", obs_line[0], obs_line[H_DISP-1]);
    end
  endtask

  task automatic test_random();
    int vv;
    for (int i = 0; i < 6; i++) begin
      vv = (i == 4) ? HEIGHT - 1 : (i == 5) ? 0 : int'($urandom_range(0, HEIGHT - 1));
      for (int h = 0; h < WIDTH; h++) begin
        lr[h] = int'($urandom_range(0, 255));
        lg[h] = int'($urandom_range(0, 255));
        lb[h] = int'($urandom_range(0, 255));
      end
      stream_line(vv, "random");
    end
  endtask

  task automatic test_mid_reset();
    int obs, expv, hp;
    for (int h = 0; h < WIDTH; h++) begin
      lr[h] = int'($urandom_range(0, 255)); lg[h] = 200; lb[h] = 30;
    end
    model_line(8);
    for (int hh = 0; hh < 150; hh++) begin
      step(hh, 8, lr[hh], lg[hh], lb[hh], lexp[hh], obs, expv, hp);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL mid_pre h=%0d: got %0d expected %0d", hp, obs, expv);
      end
    end
    rst = 1'b1;
    for (int hh = 150; hh < 153; hh++) begin
      step(hh, 8, lr[hh], lg[hh], lb[hh], lexp[hh], obs, expv, hp);
      checks++;
      if ({r_out, g_out, b_out} !== '0) begin
        errors++;
        $display("FAIL mid_reset: got %0d expected 0", r_out);
      end
    end
    rst = 1'b0;
    restart_queue();
    fill_line(60, 120, 180);
    stream_line(9, "mid_after");
  endtask

  task automatic drain();
    int obs, expv, hp;
    for (int i = 0; i < 4; i++) begin
      step(H_DISP + i, 10, 0, 0, 0, 0, obs, expv, hp);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL drain h=%0d: got %0d expected %0d", hp, obs, expv);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    h_count_in = '0; v_count_in = '0;
    r_in = '0; g_in = '0; b_in = '0;
    @(negedge clk);
    test_reset();
    test_color();
    test_blanking();
    test_step_edge();
    test_line_edges();
    test_random();
    test_mid_reset();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
